regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port between the in-order pipeline writeback (WB) and the long-latency multiply/divide unit (LU). It buffers LU results in a small FIFO and grants the port one write per cycle. It bounds LU starvation by requesting pipeline bubbles. It also keeps a pending-destination scoreboard so the ID stage can stall on operands that the LU has not yet written.

## Interface
Parameters:
- FIFO_DEPTH, 2, LU result buffer entries (power of two, ≥2)
- MAX_WAIT, 4, cycles a non-empty FIFO head may wait before stall_pipe asserts

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous, active-low reset
- wb_we  in  1  WB write request; cannot be back-pressured
- wb_reg  in  5  WB destination
- wb_data  in  32  WB data
- lu_issue  in  1  LU op dispatched this cycle
- lu_issue_reg  in  5  destination of dispatched LU op
- lu_valid  in  1  LU result valid
- lu_reg  in  5  LU result destination
- lu_data  in  32  LU result data
- lu_ready  out  1  FIFO can accept (= not full)
- rs, rt  in  5 each  ID-stage source registers
- hazard  out  1  rs or rt is pending
- stall_pipe  out  1  request a WB bubble next cycle
- rf_we, rf_waddr, rf_wdata  out  1/5/32  register file write port (registered)
- pending  out  32  scoreboard bitmap, bit 0 always 0

## Operation
- **LU handshake:** a transfer occurs when lu_valid && lu_ready. The entry is pushed at the FIFO tail. lu_ready = !full and does not depend on lu_valid.
- **Grant, evaluated each cycle in priority order:**
  1. wb_we && wb_reg≠0 → write WB.
  2. Otherwise, FIFO non-empty → pop head and write it.
  3. Otherwise, no write.
- **Register 0:** WB writes to register 0 are dropped and do not consume the slot. LU results to register 0 are pushed and popped, but rf_we stays 0 for them.
- **Full FIFO:** a push and a pop in the same cycle are legal when full. lu_ready still reads 0 that cycle, so no push occurs.
- **Starvation counter (wait_cnt, saturating at MAX_WAIT):**
  - Increments when the FIFO is non-empty and the head is not popped.
  - Clears on a pop or when the FIFO is empty.
  - stall_pipe = (wait_cnt == MAX_WAIT).
  - Pipeline contract: wb_we is 0 in the cycle after stall_pipe is seen.
  - If WB writes anyway, WB still wins and wait_cnt holds.
- **Scoreboard:**
  - lu_issue with lu_issue_reg≠0 sets pending[lu_issue_reg].
  - A FIFO pop to register r clears pending[r].
  - Set and clear to the same register in the same cycle → set wins.
  - A WB write never touches pending.
  - lu_issue to an already-pending register is illegal. The ID stage prevents it, and the bench checks it with an assertion.
- **hazard** = (rs≠0 && pending[rs]) || (rt≠0 && pending[rt]). It is combinational from the pending register.

## Timing
- Grant is decided combinationally. rf_we/rf_waddr/rf_wdata are registered, so the register file sees the write 1 cycle after the request, stable through the clk-high write phase.
- Minimum LU latency: lu_valid in cycle N, with no WB contention and an empty FIFO → pushed at edge N, popped in N+1, rf_we high in cycle N+2.
- pending clears at the same edge that launches rf_we, so hazard drops in the cycle the register file write occurs. The ID stage reads in the next low phase.
- **Reset (rst=0 at a posedge):**
  - FIFO emptied, wait_cnt=0, pending=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - stall_pipe=0, hazard=0.
  - lu_ready=0 while rst is low, 1 in the first cycle after release.
- Reset mid-operation discards all buffered LU results without writing them.

## Structure
- Package regfile_pkg holds:
  - REG_W=5, DATA_W=32, NUM_REGS=32
  - the struct wr_req_t {reg, data}, used for FIFO entries and the port mux
- Sub-module sync_fifo (parameterised depth and width, with full/empty flags and simultaneous push/pop) holds the LU buffer.
- Arbitration, wait_cnt and the scoreboard stay in the top module.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with lu_valid=1 → lu_ready=0, rf_we=0, pending=0. After release, lu_ready=1.
- **Uncontended LU:** lu_issue reg 8, then lu_valid reg 8 data 0xDEADBEEF.
  - hazard is 1 with rs=8 until the write.
  - rf_we=1, rf_waddr=8, rf_wdata=0xDEADBEEF 2 cycles after lu_valid.
  - pending[8] clears at that same edge.
- **Contention:** WB writes reg 3 every cycle while LU pushes reg 9 → stall_pipe after MAX_WAIT=4 cycles. With wb_we=0 the next cycle, reg 9 is written and stall_pipe drops.
- **Full FIFO:**
  - Continuous WB plus 3 LU results → lu_ready=0 after 2 pushes; the third is held until a pop.
  - Write order to the register file is preserved.
- **Register 0 and same-cycle set/clear:**
  - WB to reg 0 lets a FIFO pop use the slot.
  - lu_issue reg 5 in the same cycle as a pop to reg 5 → pending[5] stays 1.
- **Mid-operation reset:** 2 entries buffered, rst=0 → FIFO empty, no rf_we from the discarded entries, pending=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and write-request type for the register file write arbiter
package regfile_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with full/empty flags and same-cycle push/pop
module sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register file write port between WB and the long-latency unit
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              lu_issue,
    input  logic [REG_W-1:0]  lu_issue_reg,
    input  logic              lu_valid,
    input  logic [REG_W-1:0]  lu_reg,
    input  logic [DATA_W-1:0] lu_data,
    output logic              lu_ready,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    output logic              hazard,
    output logic              stall_pipe,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [NUM_REGS-1:0] pending
);

    localparam int             CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]  WAIT_MAX = CW'(MAX_WAIT);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    wr_req_t             lu_req;
    wr_req_t             head;
    wr_req_t             rf_req_q, rf_req_d;
    logic                rf_we_q, rf_we_d;
    logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                lu_push;
    logic                wb_grant;

    assign lu_ready = rst && !fifo_full;
    assign lu_push  = lu_valid && lu_ready;
    assign lu_req   = '{dst: lu_reg, data: lu_data};

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(wr_req_t))
    ) u_lu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (lu_push),
        .push_data (lu_req),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        wb_grant   = wb_we && (wb_reg != '0);
        fifo_pop   = !wb_grant && !fifo_empty;
        rf_we_d    = wb_grant || (fifo_pop && (head.dst != '0));
        rf_req_d   = rf_req_q;
        wait_cnt_d = wait_cnt_q;
        pending_d  = pending_q;

        if (wb_grant) begin
            rf_req_d = '{dst: wb_reg, data: wb_data};
        end else if (fifo_pop) begin
            rf_req_d = head;
        end

        if (fifo_empty || fifo_pop) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_ONE;
        end

        // Clear before set so a same-cycle issue to the popped register stays pending.
        if (fifo_pop && (head.dst != '0)) begin
            pending_d[head.dst] = 1'b0;
        end
        if (lu_issue && (lu_issue_reg != '0)) begin
            pending_d[lu_issue_reg] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we_q    <= 1'b0;
            rf_req_q   <= '0;
            wait_cnt_q <= '0;
            pending_q  <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_req_q   <= rf_req_d;
            wait_cnt_q <= wait_cnt_d;
            pending_q  <= pending_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_req_q.dst;
    assign rf_wdata   = rf_req_q.data;
    assign pending    = pending_q;
    assign stall_pipe = (wait_cnt_q == WAIT_MAX);
    assign hazard     = ((rs != '0) && pending_q[rs]) || ((rt != '0) && pending_q[rt]);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        lu_issue;
    logic [4:0]  lu_issue_reg;
    logic        lu_valid;
    logic [4:0]  lu_reg;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        hazard;
    logic        stall_pipe;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .FIFO_DEPTH (2),
        .MAX_WAIT   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_we        (wb_we),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .lu_issue     (lu_issue),
        .lu_issue_reg (lu_issue_reg),
        .lu_valid     (lu_valid),
        .lu_reg       (lu_reg),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .rs           (rs),
        .rt           (rt),
        .hazard       (hazard),
        .stall_pipe   (stall_pipe),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pending      (pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // An issue to a pending register is only legal when that register is popped the same cycle.
    logic       chk_pend = 1'b0;
    logic [4:0] chk_reg  = '0;
    always @(posedge clk) begin
        if (chk_pend) begin
            assert (rf_we && rf_waddr == chk_reg)
                else $error("lu_issue to pending register %0d", chk_reg);
        end
        chk_pend <= rst && lu_issue && (lu_issue_reg != 0) && pending[lu_issue_reg];
        chk_reg  <= lu_issue_reg;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; wb_we = 1'b0; wb_reg = '0; wb_data = '0;
        lu_issue = 1'b0; lu_issue_reg = '0; lu_valid = 1'b1; lu_reg = 5'd7; lu_data = 32'h1;
        rs = '0; rt = '0;

        // reset held with lu_valid asserted
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rst_ready", lu_ready, 0);
            check("rst_we", rf_we, 0);
            check("rst_pend", pending, 0);
        end
        check("rst_stall", stall_pipe, 0);
        check("rst_hazard", hazard, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        rst = 1'b1; lu_valid = 1'b0;
        #1;
        check("rel_ready", lu_ready, 1);

        // uncontended LU result
        lu_issue = 1'b1; lu_issue_reg = 5'd8; rs = 5'd8;
        cyc();
        lu_issue = 1'b0;
        check("unc_pend_set", pending, 32'h0000_0100);
        check("unc_haz_a", hazard, 1);
        lu_valid = 1'b1; lu_reg = 5'd8; lu_data = 32'hDEAD_BEEF;
        cyc();
        lu_valid = 1'b0;
        check("unc_haz_b", hazard, 1);
        check("unc_we_early", rf_we, 0);
        cyc();
        check("unc_we", rf_we, 1);
        check("unc_waddr", rf_waddr, 8);
        check("unc_wdata", rf_wdata, 32'hDEAD_BEEF);
        check("unc_pend_clr", pending, 0);
        check("unc_haz_clr", hazard, 0);
        cyc();
        check("unc_we_after", rf_we, 0);
        rs = '0;

        // contention: WB every cycle, LU reg 9 starves until stall
        wb_we = 1'b1; wb_reg = 5'd3; wb_data = 32'h0000_0033;
        lu_issue = 1'b1; lu_issue_reg = 5'd9;
        lu_valid = 1'b1; lu_reg = 5'd9; lu_data = 32'h0000_0099; rt = 5'd9;
        cyc();
        lu_issue = 1'b0; lu_valid = 1'b0;
        check("cont_wb_we", rf_we, 1);
        check("cont_wb_addr", rf_waddr, 3);
        check("cont_stall0", stall_pipe, 0);
        check("cont_haz", hazard, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("cont_stall", stall_pipe, (i == 4) ? 32'd1 : 32'd0);
            check("cont_wb_addr_loop", rf_waddr, 3);
        end
        cyc();
        check("cont_stall_hold", stall_pipe, 1);
        check("cont_wb_wins", rf_waddr, 3);
        wb_we = 1'b0;
        cyc();
        check("cont_lu_we", rf_we, 1);
        check("cont_lu_addr", rf_waddr, 9);
        check("cont_lu_data", rf_wdata, 32'h0000_0099);
        check("cont_stall_drop", stall_pipe, 0);
        check("cont_haz_clr", hazard, 0);
        rt = '0;

        // full FIFO with continuous WB, then drain in order
        wb_we = 1'b1; wb_reg = 5'd3; wb_data = 32'h0000_0003;
        lu_valid = 1'b1; lu_reg = 5'd10; lu_data = 32'hA0A0_A0A0;
        check("full_rdy_a", lu_ready, 1);
        cyc();
        lu_reg = 5'd11; lu_data = 32'hB1B1_B1B1;
        check("full_rdy_b", lu_ready, 1);
        cyc();
        lu_reg = 5'd12; lu_data = 32'hC2C2_C2C2;
        check("full_rdy_c", lu_ready, 0);
        cyc();
        check("full_rdy_held", lu_ready, 0);
        wb_we = 1'b0;
        cyc();
        check("full_rdy_after_pop", lu_ready, 1);
        check("full_w1_addr", rf_waddr, 10);
        check("full_w1_data", rf_wdata, 32'hA0A0_A0A0);
        cyc();
        lu_valid = 1'b0;
        check("full_w2_addr", rf_waddr, 11);
        check("full_w2_data", rf_wdata, 32'hB1B1_B1B1);
        cyc();
        check("full_w3_we", rf_we, 1);
        check("full_w3_addr", rf_waddr, 12);
        check("full_w3_data", rf_wdata, 32'hC2C2_C2C2);
        cyc();
        check("full_idle", rf_we, 0);

        // WB to reg 0 yields the slot; same-cycle set/clear of reg 5
        lu_issue = 1'b1; lu_issue_reg = 5'd5; rs = 5'd5;
        cyc();
        lu_issue = 1'b0;
        wb_we = 1'b1; wb_reg = 5'd3; wb_data = 32'h0000_0003;
        lu_valid = 1'b1; lu_reg = 5'd5; lu_data = 32'h0000_0055;
        cyc();
        lu_valid = 1'b0;
        check("r0_wb_addr", rf_waddr, 3);
        wb_reg = 5'd0; wb_data = 32'h0000_0BAD;
        lu_issue = 1'b1; lu_issue_reg = 5'd5;
        cyc();
        lu_issue = 1'b0; wb_we = 1'b0;
        check("r0_pop_we", rf_we, 1);
        check("r0_pop_addr", rf_waddr, 5);
        check("r0_pop_data", rf_wdata, 32'h0000_0055);
        check("setclr_pend", pending, 32'h0000_0020);
        check("setclr_haz", hazard, 1);
        lu_valid = 1'b1; lu_reg = 5'd5; lu_data = 32'h0000_0056;
        cyc();
        lu_valid = 1'b0;
        cyc();
        check("setclr_w_data", rf_wdata, 32'h0000_0056);
        check("setclr_pend_clr", pending, 0);
        check("setclr_haz_clr", hazard, 0);
        rs = '0;

        // LU result to reg 0 is popped without a write
        lu_valid = 1'b1; lu_reg = 5'd0; lu_data = 32'h0000_0077;
        cyc();
        lu_valid = 1'b0;
        cyc();
        check("lu_r0_we", rf_we, 0);
        check("lu_r0_pend", pending, 0);
        check("lu_r0_ready", lu_ready, 1);

        // reset with two entries buffered
        wb_we = 1'b1; wb_reg = 5'd3; lu_issue = 1'b1; lu_issue_reg = 5'd20;
        cyc();
        lu_issue_reg = 5'd21; lu_valid = 1'b1; lu_reg = 5'd20; lu_data = 32'h0000_2020;
        cyc();
        lu_issue = 1'b0; lu_reg = 5'd21; lu_data = 32'h0000_2121;
        cyc();
        lu_valid = 1'b0;
        check("mid_full", lu_ready, 0);
        check("mid_pend", pending, 32'h0030_0000);
        rst = 1'b0; wb_we = 1'b0;
        cyc();
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_pend", pending, 0);
        check("mid_rst_ready", lu_ready, 0);
        check("mid_rst_stall", stall_pipe, 0);
        rst = 1'b1;
        #1;
        check("mid_rel_ready", lu_ready, 1);
        cyc();
        check("mid_no_write_a", rf_we, 0);
        cyc();
        check("mid_no_write_b", rf_we, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
